// File: rtl/maxhpc_fifo_rr_drain.sv
// Round-robin drain arbiter: pops bursts of up to BURST_LEN words from N
// show-ahead FIFOs and forwards them through one registered valid/ready port
// tagged with the source index.
`timescale 1ns/1ps
module maxhpc_fifo_rr_drain #(
   parameter int unsigned N         = 4,
   parameter int unsigned SEL_WD    = 2,
   parameter int unsigned DATA_WD   = 8,
   parameter int unsigned BURST_LEN = 8,
   parameter int unsigned BURST_WD  = 4
) (
   input  logic                 clock,
   input  logic                 clear_n,
   input  logic                 enable,
   input  logic [N-1:0]         f_rempty,
   input  logic [N*DATA_WD-1:0] f_q,
   output logic [N-1:0]         f_rd,
   output logic                 o_valid,
   input  logic                 o_ready,
   output logic [DATA_WD-1:0]   o_data,
   output logic [SEL_WD-1:0]    o_src,
   output logic                 o_last,
   output logic                 busy
);

   localparam int unsigned           LAST_CNT = BURST_LEN - 1;
   localparam logic [SEL_WD-1:0]     LAST_SRC = SEL_WD'(N - 1);
   localparam logic [BURST_WD-1:0]   CNT_LAST = BURST_WD'(LAST_CNT);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t              state;
   state_t              state_nx;
   logic [SEL_WD-1:0]   grant;
   logic [SEL_WD-1:0]   grant_nx;
   logic [SEL_WD-1:0]   rr_ptr;
   logic [SEL_WD-1:0]   rr_ptr_nx;
   logic [BURST_WD-1:0] cnt;
   logic [BURST_WD-1:0] cnt_nx;
   logic                o_valid_nx;
   logic [DATA_WD-1:0]  o_data_nx;
   logic [SEL_WD-1:0]   o_src_nx;
   logic                o_last_nx;

   logic                g_empty;
   logic [DATA_WD-1:0]  g_q;
   logic [N-1:0]        g_onehot;
   logic                hi_found;
   logic                lo_found;
   logic [SEL_WD-1:0]   hi_idx;
   logic [SEL_WD-1:0]   lo_idx;
   logic                any_req;
   logic [SEL_WD-1:0]   pick_idx;
   logic [SEL_WD-1:0]   next_ptr;
   logic                slot_free;
   logic                pop;
   logic                burst_done;

   // Select empty flag, head word and one-hot strobe of the granted source.
   always_comb begin : grant_mux
      g_empty  = 1'b1;
      g_q      = '0;
      g_onehot = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (grant == SEL_WD'(i)) begin
            g_empty     = f_rempty[i];
            g_q         = f_q[i*DATA_WD +: DATA_WD];
            g_onehot[i] = 1'b1;
         end
      end
   end

   // Round-robin search: lowest non-empty index at or above rr_ptr, else lowest overall.
   always_comb begin : rr_scan
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (!f_rempty[i]) begin
            if (i >= int'(rr_ptr)) begin
               hi_found = 1'b1;
               hi_idx   = SEL_WD'(i);
            end else begin
               lo_found = 1'b1;
               lo_idx   = SEL_WD'(i);
            end
         end
      end
      any_req  = hi_found || lo_found;
      pick_idx = hi_found ? hi_idx : lo_idx;
   end

   // Source after the current grant, wrapping modulo N.
   assign next_ptr = (grant == LAST_SRC) ? '0 : grant + SEL_WD'(1);

   // Next-state, output-register updates and combinational pop strobe.
   always_comb begin : fsm_comb
      state_nx   = state;
      grant_nx   = grant;
      rr_ptr_nx  = rr_ptr;
      cnt_nx     = cnt;
      o_valid_nx = o_valid;
      o_data_nx  = o_data;
      o_src_nx   = o_src;
      o_last_nx  = o_last;
      f_rd       = '0;
      pop        = 1'b0;
      burst_done = 1'b0;
      slot_free  = !o_valid || o_ready;

      // A word taken by the sink frees the slot unless refilled below.
      if (o_valid && o_ready) begin
         o_valid_nx = 1'b0;
         o_last_nx  = 1'b0;
      end

      unique case (state)
         IDLE: begin
            if (enable && any_req) begin
               grant_nx = pick_idx;
               cnt_nx   = '0;
               state_nx = BURST;
            end
         end
         BURST: begin
            pop = !g_empty && slot_free;
            if (pop) begin
               f_rd       = g_onehot;
               o_data_nx  = g_q;
               o_src_nx   = grant;
               o_valid_nx = 1'b1;
               o_last_nx  = (cnt == CNT_LAST);
               cnt_nx     = cnt + BURST_WD'(1);
               burst_done = (cnt == CNT_LAST);
            end else if (g_empty && slot_free) begin
               // Source ran dry: short burst, no o_last.
               burst_done = 1'b1;
            end
            if (burst_done) begin
               state_nx  = IDLE;
               rr_ptr_nx = next_ptr;
               cnt_nx    = '0;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state   <= IDLE;
         grant   <= '0;
         rr_ptr  <= '0;
         cnt     <= '0;
         o_valid <= 1'b0;
         o_data  <= '0;
         o_src   <= '0;
         o_last  <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state   <= state_nx;
         grant   <= grant_nx;
         rr_ptr  <= rr_ptr_nx;
         cnt     <= cnt_nx;
         o_valid <= o_valid_nx;
         o_data  <= o_data_nx;
         o_src   <= o_src_nx;
         o_last  <= o_last_nx;
         busy    <= (state_nx == BURST);
      end
   end

endmodule

// File: tb/tb_maxhpc_fifo_rr_drain.sv
// Bench for maxhpc_fifo_rr_drain: queue-backed show-ahead FIFOs and a
// transaction-level round-robin model producing the expected word stream.
`timescale 1ns/1ps
module tb_maxhpc_fifo_rr_drain;

   localparam int N      = 4;
   localparam int SEL_WD = 2;
   localparam int DW     = 8;
   localparam int BL     = 8;
   localparam int BW     = 4;

   logic              clock = 1'b0;
   logic              clear_n;
   logic              enable;
   logic [N-1:0]      f_rempty;
   logic [N*DW-1:0]   f_q;
   logic [N-1:0]      f_rd;
   logic              o_valid;
   logic              o_ready;
   logic [DW-1:0]     o_data;
   logic [SEL_WD-1:0] o_src;
   logic              o_last;
   logic              busy;

   maxhpc_fifo_rr_drain #(
      .N(N), .SEL_WD(SEL_WD), .DATA_WD(DW), .BURST_LEN(BL), .BURST_WD(BW)
   ) dut (
      .clock(clock), .clear_n(clear_n), .enable(enable),
      .f_rempty(f_rempty), .f_q(f_q), .f_rd(f_rd),
      .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
      .o_src(o_src), .o_last(o_last), .busy(busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      int src;
      int data;
      int last;
      int gap;   // expected cycles since previous accepted word, 0 = unchecked
   } exp_t;

   exp_t          expq[$];
   logic [DW-1:0] srcq[N][$];
   int            wctr[N];
   int            n_checks   = 0;
   int            n_fail     = 0;
   int            m_ptr      = 0;
   int            cyc        = 0;
   int            last_acc   = -1;
   int            n_pop      = 0;
   int            stall_from = -1;
   bit            chk_gap    = 1'b0;
   bit            rand_rdy   = 1'b0;
   bit            rand_en    = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic load(input int s, input int cnt);
      for (int k = 0; k < cnt; k++) begin
         srcq[s].push_back(DW'(s * 64 + wctr[s]));
         wctr[s] = (wctr[s] + 1) % 64;
      end
   endtask

   // Round-robin grant order over the queued words: each grant takes up to BL
   // words; a full burst costs one bubble, a short one two (empty seen, then arbitrate).
   function automatic void build_exp();
      int  pos[N];
      int  g;
      int  take;
      bit  first;
      bit  prev_full;
      bit  done;
      for (int s = 0; s < N; s++) pos[s] = 0;
      first     = 1'b1;
      prev_full = 1'b0;
      done      = 1'b0;
      while (!done) begin
         g = -1;
         for (int k = 0; k < N; k++) begin
            int s;
            s = (m_ptr + k) % N;
            if (g < 0 && pos[s] < srcq[s].size()) g = s;
         end
         if (g < 0) begin
            done = 1'b1;
         end else begin
            take = srcq[g].size() - pos[g];
            if (take > BL) take = BL;
            for (int k = 0; k < take; k++) begin
               exp_t e;
               e.src  = g;
               e.data = int'(srcq[g][pos[g] + k]);
               e.last = (take == BL && k == BL - 1) ? 1 : 0;
               e.gap  = (k > 0) ? 1 : (first ? 0 : (prev_full ? 2 : 3));
               expq.push_back(e);
            end
            first     = 1'b0;
            prev_full = (take == BL);
            pos[g]   += take;
            m_ptr     = (g + 1) % N;
         end
      end
   endfunction

   task automatic drive_fifo();
      for (int i = 0; i < N; i++) begin
         f_rempty[i]       = (srcq[i].size() == 0);
         f_q[i*DW +: DW]   = (srcq[i].size() != 0) ? srcq[i][0] : '0;
      end
   endtask

   // One clock: drive inputs after negedge, check settled outputs, apply pops at posedge.
   task automatic cycle();
      logic [N-1:0] pops;
      exp_t         e;
      @(negedge clock);
      cyc++;
      if (rand_rdy) o_ready = ($urandom_range(0, 3) != 0);
      if (rand_en)  enable  = ($urandom_range(0, 4) != 0);
      if (stall_from >= 0) o_ready = !(cyc >= stall_from && cyc < stall_from + 5);
      drive_fifo();
      #1;
      check("rd_onehot0", 32'($onehot0(f_rd)), 32'd1);
      if (f_rd != '0) begin
         check("rd_nonempty", 32'(f_rd & f_rempty), 32'd0);
         check("rd_busy", 32'(busy), 32'd1);
      end
      if (o_valid && !o_ready) check("rd_stall", 32'(f_rd), 32'd0);
      if (o_valid && o_ready) begin
         if (expq.size() == 0) begin
            check("extra_word", 32'(o_valid), 32'd0);
         end else begin
            e = expq.pop_front();
            check("src", 32'(o_src), 32'(e.src));
            check("data", 32'(o_data), 32'(e.data));
            check("last", 32'(o_last), 32'(e.last));
            if (chk_gap && e.gap != 0 && last_acc >= 0)
               check("gap", 32'(cyc - last_acc), 32'(e.gap));
         end
         last_acc = cyc;
      end
      pops = f_rd;
      @(posedge clock);
      for (int i = 0; i < N; i++)
         if (pops[i] && srcq[i].size() != 0) begin
            void'(srcq[i].pop_front());
            n_pop++;
         end
      #1;
   endtask

   task automatic run_phase(input string name, input int budget);
      int n;
      n        = 0;
      last_acc = -1;
      build_exp();
      while (expq.size() != 0 && n < budget) begin
         cycle();
         n++;
      end
      check({name, "_timeout"}, 32'(expq.size()), 32'd0);
      expq.delete();
      repeat (4) cycle();
      check({name, "_idle_busy"}, 32'(busy), 32'd0);
      check({name, "_idle_valid"}, 32'(o_valid), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      for (int s = 0; s < N; s++) wctr[s] = 0;
      clear_n  = 1'b0;
      enable   = 1'b1;
      o_ready  = 1'b0;
      f_rempty = '0;
      f_q      = '1;

      // Reset values, with every FIFO claiming data.
      repeat (2) @(negedge clock);
      #1;
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_data", 32'(o_data), 32'd0);
      check("rst_src", 32'(o_src), 32'd0);
      check("rst_last", 32'(o_last), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rd", 32'(f_rd), 32'd0);
      drive_fifo();
      @(negedge clock);
      clear_n = 1'b1;
      o_ready = 1'b1;

      // Single source, short burst.
      chk_gap = 1'b1;
      load(2, 3);
      run_phase("single", 200);

      // All sources loaded, full-speed bursts.
      for (int s = 0; s < N; s++) load(s, 20);
      run_phase("full", 400);

      // Deterministic 5-cycle stall mid-burst.
      chk_gap    = 1'b0;
      load(1, 12);
      stall_from = cyc + 4;
      run_phase("stall5", 200);
      stall_from = -1;
      o_ready    = 1'b1;

      // Random backpressure.
      rand_rdy = 1'b1;
      load(1, 12);
      load(3, 5);
      run_phase("bp", 400);
      rand_rdy = 1'b0;
      o_ready  = 1'b1;

      // enable dropped mid-burst: burst completes, no new grant.
      chk_gap  = 1'b1;
      n_pop    = 0;
      last_acc = -1;
      load(1, 8);
      build_exp();
      n = 0;
      while (n_pop == 0 && n < 20) begin cycle(); n++; end
      check("en_first_pop", 32'(n_pop > 0), 32'd1);
      enable = 1'b0;
      n = 0;
      while (expq.size() != 0 && n < 100) begin cycle(); n++; end
      check("en_drain", 32'(expq.size()), 32'd0);
      load(3, 4);
      repeat (2) cycle();
      for (int k = 0; k < 10; k++) begin
         cycle();
         check("en_hold_busy", 32'(busy), 32'd0);
         check("en_hold_rd", 32'(f_rd), 32'd0);
      end
      enable = 1'b1;
      run_phase("en_resume", 100);

      // Wrap fairness: pointer at 1, sources 0 and 2 loaded -> 2,0,2,0.
      load(0, 2);
      run_phase("pre_wrap", 100);
      load(0, 10);
      load(2, 10);
      run_phase("wrap", 200);

      // Randomized traffic with random backpressure and enable.
      chk_gap  = 1'b0;
      rand_rdy = 1'b1;
      rand_en  = 1'b1;
      for (int r = 0; r < 6; r++) begin
         for (int s = 0; s < N; s++) load(s, int'($urandom_range(0, 20)));
         run_phase("rand", 3000);
      end
      rand_rdy = 1'b0;
      rand_en  = 1'b0;
      enable   = 1'b1;
      o_ready  = 1'b1;

      // Reset mid-burst while the output is stalled.
      chk_gap = 1'b1;
      load(0, 2);
      run_phase("pre_rst", 100);
      o_ready = 1'b0;
      load(2, 3);
      load(0, 3);
      n = 0;
      while (!o_valid && n < 20) begin cycle(); n++; end
      check("rst_mid_valid", 32'(o_valid), 32'd1);
      check("rst_mid_src", 32'(o_src), 32'd2);
      @(negedge clock);
      clear_n = 1'b0;
      #1;
      check("rst_mid_valid0", 32'(o_valid), 32'd0);
      check("rst_mid_rd", 32'(f_rd), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_last", 32'(o_last), 32'd0);
      @(negedge clock);
      clear_n = 1'b1;
      o_ready = 1'b1;
      m_ptr   = 0;
      expq.delete();
      run_phase("post_rst", 100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/maxhpc_fifo_rr_drain.md
Name: maxhpc_fifo_rr_drain

Overview:
Round-robin drain arbiter that shares one downstream sink between N single-clock FIFOs.
- Sources are FIFOs configured SHOWAHEAD="ON".
- The block issues per-FIFO rd pops and forwards words through one registered valid/ready output, tagged with the source index.
- Each grant is a burst of at most BURST_LEN words. Bursts bound latency per source and keep source words contiguous at the sink.
- It sits between the per-channel FIFOs and a shared consumer such as a DMA or serializer.

Parameters:
N, 4, number of source FIFOs (1..16)
SEL_WD, 2, width of the source index; must be at least 1 and at least ceil(log2(N))
DATA_WD, 8, word width; equals the FIFO DATA_WD
BURST_LEN, 8, maximum words popped per grant (1..2^BURST_WD-1)
BURST_WD, 4, burst counter width

Ports:
clock  in  1  single clock; all state on its rising edge
clear_n  in  1  asynchronous active-low reset
enable  in  1  high permits new grants
f_rempty  in  N  per-source FIFO rempty
f_q  in  N*DATA_WD  per-source show-ahead FIFO q; source i occupies bits [i*DATA_WD +: DATA_WD]
f_rd  out  N  per-source pop strobe; combinational, one-hot or zero
o_valid  out  1  output word valid
o_ready  in  1  sink accepts the word
o_data  out  DATA_WD  output word
o_src  out  SEL_WD  source index of o_data
o_last  out  1  final word of a BURST_LEN-limited burst
busy  out  1  high while in state BURST

Behaviour:
- Reset (clear_n low, asynchronous): state=IDLE, grant=0, rr_ptr=0, cnt=0, o_valid=0, o_data=0, o_src=0, o_last=0.
  - f_rd decodes only from registers and evaluates to 0 throughout reset.
  - A reset in mid-burst drops the held output word. Words already popped are lost by design.
- Output slot: slot_free = !o_valid || o_ready.
- IDLE:
  - If enable and any f_rempty bit is 0, grant <= the first index i with !f_rempty[i], searched from rr_ptr upward modulo N. Then cnt <= 0, state <= BURST.
  - Otherwise stay in IDLE. f_rd=0 in IDLE.
  - Arbitration costs 1 cycle of latency, from IDLE to the first pop.
- BURST:
  - pop = !f_rempty[grant] && slot_free; f_rd[grant] = pop.
  - On pop: o_data <= f_q[grant], o_src <= grant, o_valid <= 1, cnt <= cnt+1, o_last <= (cnt==BURST_LEN-1).
  - When o_valid && o_ready && !pop: o_valid <= 0, o_last <= 0.
  - When !slot_free, all output registers hold. o_data, o_src and o_last stay stable while o_valid && !o_ready.
  - Exit on a pop with cnt==BURST_LEN-1: state <= IDLE, rr_ptr <= (grant+1) mod N.
  - Exit when f_rempty[grant] && slot_free: the burst ends short, state <= IDLE, rr_ptr <= (grant+1) mod N, o_last is not asserted. A stall with !slot_free does not end the burst.
  - enable going low in BURST does not abort the burst. It only blocks the next grant.
- Fairness: after a granted source's burst, that source has the lowest priority. With all sources continuously non-empty, grants cycle 0,1,..,N-1,0.
- Throughput: with o_ready held high, one word per cycle within a burst, plus 1 idle arbitration cycle between bursts.
- N=1: rr_ptr stays 0 and source 0 is regranted after each burst.
- BURST_LEN=1: every word carries o_last=1 and one arbitration cycle follows each word.
- cnt never exceeds BURST_LEN-1. rr_ptr wraps from N-1 to 0. Index arithmetic is modulo N, not 2^SEL_WD.
- busy = (state==BURST).

Test Plan:
- Reset mid-burst: clear_n low for 1 cycle while o_valid=1, o_ready=0 -> o_valid=0, f_rd=0, busy=0 immediately. The next grant starts from source 0.
- Single source, source 2 holding 3 words A,B,C, o_ready=1, BURST_LEN=8 -> after 1 arbitration cycle, f_rd[2] pulses 3 consecutive cycles. o_data shows A,B,C with o_src=2 and o_last=0 on all. busy drops the cycle after f_rempty[2] rises.
- All 4 sources holding 20 words each, o_ready=1, BURST_LEN=8 -> bursts of 8 in source order 0,1,2,3,0,... o_last=1 on every 8th word of each burst. One bubble cycle appears between bursts.
- Backpressure: o_ready low for 5 cycles mid-burst -> f_rd=0 during the stall, o_data/o_src held. The burst does not end. Words resume in order after o_ready returns with no loss or duplicate.
- enable=0 in mid-burst of source 1 with 8 words queued -> all 8 words delivered, then IDLE. No new grant until enable=1.
- Wrap fairness with N=3, sources 0 and 2 non-empty and rr_ptr=1 -> source 2 is granted first, then source 0, then source 2.
